// File: rtl/tx_arbiter_pkg.sv
// rtl/tx_arbiter_pkg.sv - shared defaults, FSM encoding and ring-index helper for tx_arbiter
//
// Purpose: common definitions for tx_arbiter and its round-robin picker.
//   - default record field widths, requester count and busy timeout
//   - FSM state encoding (IDLE, ISSUE, WAIT_HI, WAIT_LO)
//   - ring_add: modular add on a ring of n entries, for operands already below n
// Ports: none (package).

package tx_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int BS_W_DEF    = 8;
  localparam int TS_W_DEF    = 32;
  localparam int BUSY_TO_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_e;

  // base and off are both below n, so a single conditional subtract replaces a modulo.
  function automatic int ring_add(int base, int off, int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick from a request vector and a start pointer
//
// Purpose: scans requests starting at i_ptr and wrapping around; the first set bit wins.
// Ports:
//   i_req    in   NUM_REQ   request vector
//   i_ptr    in   IDX_W     index with highest priority this pick
//   o_grant  out  NUM_REQ   one-hot grant (zero when no request)
//   o_idx    out  IDX_W     index of the granted requester
//   o_any    out  1         at least one request present

module rr_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_j = IDX_W'(ring_add(int'(i_ptr), off, NUM_REQ));
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin sharing of one UART transmitter among NUM_REQ record sources
//
// Purpose: one record buffer per requester, round-robin grant, one record at a time to the
//   UART, each hand-off paced on tx_busy (rise with timeout, then fall).
// Ports:
//   clk            in   1                 system clock
//   reset          in   1                 asynchronous, active-high reset
//   req_addr       in   NUM_REQ*ADDR_W    requester k at [k*ADDR_W +: ADDR_W]
//   req_buysell    in   NUM_REQ*BS_W      requester k at [k*BS_W +: BS_W]
//   req_timestamp  in   NUM_REQ*TS_W      requester k at [k*TS_W +: TS_W]
//   req_dv         in   NUM_REQ           one-cycle record strobe per requester
//   tx_addr        out  ADDR_W            record to UART (held between strobes)
//   tx_buysell     out  BS_W              record to UART (held between strobes)
//   tx_timestamp   out  TS_W              record to UART (held between strobes)
//   tx_dv          out  1                 one-cycle strobe, fields valid in the same cycle
//   tx_busy        in   1                 UART transmitting
//   grant_id       out  IDX_W             index of the last granted requester
//   pending        out  NUM_REQ           slot k holds an unsent record
//   drop_flag      out  NUM_REQ           sticky: a record from k was discarded
//   drop_clr       in   1                 clears all drop_flag bits

module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_DEF,
  parameter int  ADDR_W  = ADDR_W_DEF,
  parameter int  BS_W    = BS_W_DEF,
  parameter int  TS_W    = TS_W_DEF,
  parameter int  BUSY_TO = BUSY_TO_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*BS_W-1:0]   req_buysell,
  input  logic [NUM_REQ*TS_W-1:0]   req_timestamp,
  input  logic [NUM_REQ-1:0]        req_dv,
  output logic [ADDR_W-1:0]         tx_addr,
  output logic [BS_W-1:0]           tx_buysell,
  output logic [TS_W-1:0]           tx_timestamp,
  output logic                      tx_dv,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic [NUM_REQ-1:0]        pending,
  output logic [NUM_REQ-1:0]        drop_flag,
  input  logic                      drop_clr
);

  localparam int CNT_W = $clog2(BUSY_TO + 1);

  // Slot storage
  logic [ADDR_W-1:0]  r_slot_addr [NUM_REQ];
  logic [BS_W-1:0]    r_slot_bs   [NUM_REQ];
  logic [TS_W-1:0]    r_slot_ts   [NUM_REQ];
  logic [NUM_REQ-1:0] r_valid;
  logic [NUM_REQ-1:0] r_drop;

  // FSM state
  tx_state_e          r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_win_oh;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [NUM_REQ-1:0] w_free;
  logic [NUM_REQ-1:0] w_accept;
  logic [NUM_REQ-1:0] w_drop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req   (r_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The winner's slot is released at the end of ISSUE; a strobe landing in that same
  // cycle refills the slot instead of being counted as an overflow.
  always_comb begin
    w_free   = (r_state == ST_ISSUE) ? r_win_oh : '0;
    w_accept = req_dv & (~r_valid | w_free);
    w_drop   = req_dv & r_valid & ~w_free;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_drop  <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        r_slot_addr[k] <= '0;
        r_slot_bs[k]   <= '0;
        r_slot_ts[k]   <= '0;
      end
    end else begin
      r_valid <= w_accept | (r_valid & ~w_free);
      // A new drop outranks a simultaneous clear.
      r_drop  <= w_drop | (r_drop & ~{NUM_REQ{drop_clr}});
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_accept[k]) begin
          r_slot_addr[k] <= req_addr[k*ADDR_W +: ADDR_W];
          r_slot_bs[k]   <= req_buysell[k*BS_W +: BS_W];
          r_slot_ts[k]   <= req_timestamp[k*TS_W +: TS_W];
        end
      end
    end
  end

  assign pending   = r_valid;
  assign drop_flag = r_drop;

  // Outputs are registered on the IDLE->ISSUE edge so that tx_dv and the fields are
  // visible for exactly the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_win_oh     <= '0;
      r_cnt        <= '0;
      tx_addr      <= '0;
      tx_buysell   <= '0;
      tx_timestamp <= '0;
      tx_dv        <= 1'b0;
      grant_id     <= '0;
    end else begin
      tx_dv <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any && !tx_busy) begin
            tx_addr      <= r_slot_addr[w_idx];
            tx_buysell   <= r_slot_bs[w_idx];
            tx_timestamp <= r_slot_ts[w_idx];
            tx_dv        <= 1'b1;
            grant_id     <= w_idx;
            r_win_oh     <= w_grant;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_ptr   <= IDX_W'(ring_add(int'(grant_id), 1, NUM_REQ));
          r_cnt   <= CNT_W'(BUSY_TO);
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          // The counter covers BUSY_TO cycles of waiting; a UART that never answers
          // must not stall the other requesters.
          if (tx_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int TW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*BW-1:0]  req_buysell = '0;
  logic [NR*TW-1:0]  req_timestamp = '0;
  logic [NR-1:0]     req_dv = '0;
  logic [AW-1:0]     tx_addr;
  logic [BW-1:0]     tx_buysell;
  logic [TW-1:0]     tx_timestamp;
  logic              tx_dv;
  logic              tx_busy = 1'b0;
  logic [1:0]        grant_id;
  logic [NR-1:0]     pending;
  logic [NR-1:0]     drop_flag;
  logic              drop_clr = 1'b0;

  tx_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .BS_W    (BW),
    .TS_W    (TW),
    .BUSY_TO (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_addr      (req_addr),
    .req_buysell   (req_buysell),
    .req_timestamp (req_timestamp),
    .req_dv        (req_dv),
    .tx_addr       (tx_addr),
    .tx_buysell    (tx_buysell),
    .tx_timestamp  (tx_timestamp),
    .tx_dv         (tx_dv),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .pending       (pending),
    .drop_flag     (drop_flag),
    .drop_clr      (drop_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] bs;
    logic [31:0] ts;
    logic [1:0] gid;
  } dv_rec_t;

  typedef struct {
    int          k;
    logic [7:0]  addr;
    logic [7:0]  bs;
    logic [31:0] ts;
    logic [1:0]  exp_gid;
    logic [3:0]  exp_pend;
  } vec_t;

  dv_rec_t log_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int busy_len = 0;
  int busy_rem = 0;
  bit busy_start = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock; then the UART model reacts and tx_dv strobes are logged.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (busy_start) begin
      tx_busy = 1'b1;
      busy_rem = busy_len;
      busy_start = 0;
    end else if (busy_rem > 0) begin
      busy_rem--;
      if (busy_rem == 0) tx_busy = 1'b0;
    end
    if (tx_dv) begin
      chk("dv_while_busy", 64'(tx_busy), 64'(0));
      log_q.push_back('{cyc, tx_addr, tx_buysell, tx_timestamp, grant_id});
      if (busy_len > 0) busy_start = 1;
    end
  endtask

  task automatic set_req(int k, logic [7:0] a, logic [7:0] b, logic [31:0] t);
    req_addr[k*AW +: AW] = a;
    req_buysell[k*BW +: BW] = b;
    req_timestamp[k*TW +: TW] = t;
    req_dv[k] = 1'b1;
  endtask

  task automatic pulse();
    cycle();
    req_dv = '0;
    drop_clr = 1'b0;
  endtask

  task automatic wait_dvs(string name, int n, int budget);
    int i;
    i = 0;
    while (log_q.size() < n && i < budget) begin
      cycle();
      i++;
    end
    chk(name, 64'(log_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tx_busy = 1'b0;
    busy_rem = 0;
    busy_start = 0;
    req_dv = '0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    log_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    int t0;

    vt[0] = '{2, 8'h05, 8'h01, 32'h12345678, 2'd2, 4'b0100};
    vt[1] = '{0, 8'hA5, 8'h02, 32'hDEADBEEF, 2'd0, 4'b0001};
    vt[2] = '{3, 8'hFF, 8'h80, 32'h00000000, 2'd3, 4'b1000};
    vt[3] = '{1, 8'h00, 8'hFF, 32'hFFFFFFFF, 2'd1, 4'b0010};

    // Reset state
    cycle();
    chk("rst_tx_dv", 64'(tx_dv), 64'(0));
    chk("rst_tx_addr", 64'(tx_addr), 64'(0));
    chk("rst_tx_bs", 64'(tx_buysell), 64'(0));
    chk("rst_tx_ts", 64'(tx_timestamp), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_drop", 64'(drop_flag), 64'(0));
    reset = 1'b0;
    cycle();
    chk("post_rst_pending", 64'(pending), 64'(0));

    // Single records from the vector table
    busy_len = 10;
    for (int i = 0; i < 4; i++) begin
      log_q.delete();
      t0 = cyc;
      set_req(vt[i].k, vt[i].addr, vt[i].bs, vt[i].ts);
      pulse();
      chk($sformatf("single%0d_pend", i), 64'(pending), 64'(vt[i].exp_pend));
      wait_dvs($sformatf("single%0d_dv", i), 1, 8);
      if (log_q.size() >= 1) begin
        chk($sformatf("single%0d_lat", i), 64'(log_q[0].cyc - t0), 64'(2));
        chk($sformatf("single%0d_addr", i), 64'(log_q[0].addr), 64'(vt[i].addr));
        chk($sformatf("single%0d_bs", i), 64'(log_q[0].bs), 64'(vt[i].bs));
        chk($sformatf("single%0d_ts", i), 64'(log_q[0].ts), 64'(vt[i].ts));
        chk($sformatf("single%0d_gid", i), 64'(log_q[0].gid), 64'(vt[i].exp_gid));
      end
      repeat (16) cycle();
      chk($sformatf("single%0d_once", i), 64'(log_q.size()), 64'(1));
      chk($sformatf("single%0d_empty", i), 64'(pending), 64'(0));
    end

    // Fairness: all four at once, twice
    do_reset();
    busy_len = 5;
    for (int k = 0; k < 4; k++) set_req(k, 8'(8'h10 + k), 8'(k), 32'(32'h10000000 + k));
    pulse();
    chk("fair_pend", 64'(pending), 64'(4'b1111));
    wait_dvs("fair1_cnt", 4, 60);
    if (log_q.size() >= 2) chk("fair_period", 64'(log_q[1].cyc - log_q[0].cyc), 64'(8));
    repeat (10) cycle();
    for (int k = 0; k < 4; k++) set_req(k, 8'(8'h20 + k), 8'(k), 32'(32'h20000000 + k));
    pulse();
    wait_dvs("fair2_cnt", 8, 60);
    for (int i = 0; i < log_q.size() && i < 8; i++) begin
      chk($sformatf("fair_gid%0d", i), 64'(log_q[i].gid), 64'(i % 4));
      chk($sformatf("fair_addr%0d", i), 64'(log_q[i].addr),
          64'((i < 4) ? (8'h10 + i) : (8'h20 + i - 4)));
    end
    repeat (10) cycle();

    // Overflow on requester 1 while the UART is busy
    busy_len = 10;
    log_q.delete();
    set_req(0, 8'h30, 8'h03, 32'h30000000);
    pulse();
    wait_dvs("ovf_first", 1, 8);
    cycle();
    cycle();
    set_req(1, 8'h31, 8'h11, 32'h31000001);
    pulse();
    chk("ovf_pend_a", 64'(pending), 64'(4'b0010));
    chk("ovf_nodrop_a", 64'(drop_flag), 64'(0));
    set_req(1, 8'h32, 8'h12, 32'h32000002);
    pulse();
    chk("ovf_drop_b", 64'(drop_flag), 64'(4'b0010));
    chk("ovf_pend_b", 64'(pending), 64'(4'b0010));
    set_req(1, 8'h33, 8'h13, 32'h33000003);
    drop_clr = 1'b1;
    pulse();
    chk("ovf_set_wins", 64'(drop_flag), 64'(4'b0010));
    wait_dvs("ovf_sent", 2, 30);
    if (log_q.size() >= 2) begin
      chk("ovf_addr", 64'(log_q[1].addr), 64'(8'h31));
      chk("ovf_ts", 64'(log_q[1].ts), 64'(32'h31000001));
      chk("ovf_gid", 64'(log_q[1].gid), 64'(1));
    end
    repeat (20) cycle();
    chk("ovf_no_extra", 64'(log_q.size()), 64'(2));
    chk("ovf_sticky", 64'(drop_flag), 64'(4'b0010));
    drop_clr = 1'b1;
    cycle();
    drop_clr = 1'b0;
    chk("ovf_cleared", 64'(drop_flag), 64'(0));

    // Reload slot 0 in its own ISSUE cycle
    busy_len = 5;
    log_q.delete();
    set_req(0, 8'h40, 8'h04, 32'h40000000);
    pulse();
    cycle();
    chk("reload_issue_dv", 64'(tx_dv), 64'(1));
    set_req(0, 8'h41, 8'h14, 32'h41000001);
    pulse();
    chk("reload_nodrop", 64'(drop_flag), 64'(0));
    chk("reload_pend", 64'(pending), 64'(4'b0001));
    wait_dvs("reload_cnt", 2, 20);
    if (log_q.size() >= 2) begin
      chk("reload_addr", 64'(log_q[1].addr), 64'(8'h41));
      chk("reload_ts", 64'(log_q[1].ts), 64'(32'h41000001));
      chk("reload_gid", 64'(log_q[1].gid), 64'(0));
    end
    repeat (10) cycle();

    // Busy never rises: 16 cycles in WAIT_HI, one IDLE, then next ISSUE
    busy_len = 0;
    log_q.delete();
    set_req(2, 8'h52, 8'h05, 32'h52000000);
    set_req(3, 8'h53, 8'h06, 32'h53000000);
    pulse();
    wait_dvs("to_cnt", 2, 40);
    if (log_q.size() >= 2) begin
      chk("to_gid0", 64'(log_q[0].gid), 64'(2));
      chk("to_gid1", 64'(log_q[1].gid), 64'(3));
      chk("to_gap", 64'(log_q[1].cyc - log_q[0].cyc), 64'(18));
      chk("to_addr1", 64'(log_q[1].addr), 64'(8'h53));
    end
    repeat (20) cycle();

    // Reset while waiting for busy to fall, two slots pending
    busy_len = 20;
    log_q.delete();
    set_req(3, 8'h63, 8'h07, 32'h63000000);
    pulse();
    wait_dvs("rst_first", 1, 8);
    repeat (3) cycle();
    set_req(1, 8'h61, 8'h08, 32'h61000000);
    set_req(2, 8'h62, 8'h09, 32'h62000000);
    pulse();
    chk("mid_pend", 64'(pending), 64'(4'b0110));
    reset = 1'b1;
    tx_busy = 1'b0;
    busy_rem = 0;
    busy_start = 0;
    cycle();
    chk("mid_rst_dv", 64'(tx_dv), 64'(0));
    chk("mid_rst_addr", 64'(tx_addr), 64'(0));
    chk("mid_rst_bs", 64'(tx_buysell), 64'(0));
    chk("mid_rst_ts", 64'(tx_timestamp), 64'(0));
    chk("mid_rst_gid", 64'(grant_id), 64'(0));
    chk("mid_rst_pend", 64'(pending), 64'(0));
    reset = 1'b0;
    repeat (30) cycle();
    chk("mid_rst_no_dv", 64'(log_q.size()), 64'(1));
    chk("mid_rst_pend_after", 64'(pending), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
